mem_port_arbiter: RTL and testbench
===================================

Name:
mem_port_arbiter

Overview:
- Shares the single AXI_master_SRAM user port between the instruction fetch path (read-only) and the LSU (read/write).
- Captures one-cycle request pulses from each requester, serialises them onto the bus one transaction at a time, and routes the completion pulse back to the owner.
- Sits between ifetch_cache / LSU and the shared AXI_master_SRAM instance.

Parameters:
- ADDR_W, 64, address width of all address ports.
- DATA_W, 64, data width; the mask width is DATA_W/8.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- ifu_rreq  in  1  one-cycle fetch read request pulse.
- ifu_raddr  in  ADDR_W  fetch address, valid with ifu_rreq.
- ifu_rask  out  1  one-cycle pulse: fetch read complete, data on rdata.
- lsu_rreq  in  1  one-cycle LSU read request pulse.
- lsu_raddr  in  ADDR_W  LSU read address, valid with lsu_rreq.
- lsu_rask  out  1  one-cycle pulse: LSU read complete, data on rdata.
- lsu_wreq  in  1  one-cycle LSU write request pulse.
- lsu_waddr  in  ADDR_W  write address, valid with lsu_wreq.
- lsu_wdata  in  DATA_W  write data, valid with lsu_wreq.
- lsu_wmask  in  DATA_W/8  byte strobes, valid with lsu_wreq.
- lsu_wask  out  1  one-cycle pulse: LSU write complete.
- rdata  out  DATA_W  read data shared by both requesters; meaningful only while ifu_rask or lsu_rask is high.
- bus_rreq  out  1  one-cycle read request pulse to AXI_master_SRAM.
- bus_raddr  out  ADDR_W  read address, valid with bus_rreq.
- bus_rdata  in  DATA_W  read data, valid with bus_rask.
- bus_rask  in  1  one-cycle read completion pulse from the bus.
- bus_wreq  out  1  one-cycle write request pulse to the bus.
- bus_waddr  out  ADDR_W  write address, valid with bus_wreq.
- bus_wdata  out  DATA_W  write data, valid with bus_wreq.
- bus_wmask  out  DATA_W/8  write strobes, valid with bus_wreq.
- bus_wask  in  1  one-cycle write completion pulse from the bus.
- busy  out  1  high when a transaction is in flight or any request is pending.

Behaviour:
- Reset: every output is 0. State = IDLE. All pending slots cleared. Priority pointer = LSU.
- Capture: each requester has a one-deep slot. A request pulse sets the slot pending and latches address, data and mask. The slot captures in any state, including the cycle a bus ask arrives. The slot clears when its ask is driven.
- Requester rules (assertions): a requester must not issue a new request while its slot is pending. lsu_rreq and lsu_wreq are never high in the same cycle.
- FSM states: IDLE, RD_IFU, RD_LSU, WR_LSU.
- IDLE arbitration uses slots that were pending at the clock edge, so a request pulse at cycle N is first eligible at N+1.
- Fixed priority: LSU write > LSU read > IFU read.
- On grant: the matching bus_*req pulses for exactly one cycle with the latched fields, and state moves to the matching RD_*/WR_* state.
- Minimum latency: request at N → bus_rreq/bus_wreq at N+1.
- RD_IFU: on bus_rask, ifu_rask = 1 in the same cycle and rdata = bus_rdata (combinational); state → IDLE.
- RD_LSU: on bus_rask, lsu_rask = 1 in the same cycle and rdata = bus_rdata (combinational); state → IDLE.
- WR_LSU: on bus_wask, lsu_wask = 1 in the same cycle; state → IDLE.
- The next bus request is issued no earlier than the cycle after an ask, so back-to-back transactions have a one-idle-cycle gap.
- Stray asks: a bus ask in IDLE, or of the wrong kind for the current state, is dropped; no requester ask is produced (assertion).
- rdata is 0 whenever neither read ask is high.
- Reset mid-transaction: the FSM returns to IDLE and pending slots are cleared. The downstream transaction is abandoned and its late ask is dropped as stray.
- busy = (state != IDLE) | any slot pending.

Optional Feature:
- Macro: MEM_PORT_ARB_RR_EN.
- Defined: round-robin between two requesters, IFU and LSU (LSU read and write count as one requester). The priority pointer flips to the other requester after each grant. Within LSU, a write still beats a read.
- Undefined: fixed priority as described in Behaviour; no pointer register is built.

Decomposition:
- Package mem_port_arb_pkg: state enum arb_state_e (IDLE, RD_IFU, RD_LSU, WR_LSU) and requester enum arb_req_e (REQ_IFU, REQ_LSU).
- One sub-module, mem_port_req_slot: a one-deep pending flag plus payload register with set and clear inputs, instantiated per requester.

Test Plan:
- Single fetch: ifu_rreq at cycle 2 with raddr 0x80000000 → bus_rreq at 3 with bus_raddr 0x80000000. bus_rask at 6 with bus_rdata 0x00000013 → ifu_rask at 6 with rdata 0x13; busy low at 7.
- Simultaneous: ifu_rreq(0x80000004) and lsu_wreq(0x80001000, data 0xDEADBEEF, mask 0x0F) at cycle 2 → bus_wreq at 3. bus_wask at 5 → lsu_wask at 5. bus_rreq(0x80000004) at 6.
- Capture during busy: lsu_rreq(0x80002000) at cycle 4 while RD_IFU is in flight. IFU ask at 7 → bus_rreq(0x80002000) at 8. bus_rask at 9 → lsu_rask at 9, and ifu_rask stays 0.
- Reset mid-read: rst high at the cycle after bus_rreq, then bus_rask arrives 3 cycles later → no ifu_rask or lsu_rask, busy 0, stray-ask assertion fires.
- RR on (MEM_PORT_ARB_RR_EN): IFU and LSU each re-request immediately after every ask for 4 grants → grant order LSU, IFU, LSU, IFU. RR off: the same stimulus gives LSU on all 4 grants, with IFU served only once LSU stops requesting.

Source files
------------

// File: rtl/mem_port_arb_pkg.sv
// Shared types for the memory port arbiter: FSM state and requester identity.
package mem_port_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RD_IFU,
    RD_LSU,
    WR_LSU
  } arb_state_e;

  typedef enum logic {
    REQ_IFU,
    REQ_LSU
  } arb_req_e;

endpackage

// File: rtl/mem_port_req_slot.sv
// One-deep request holding slot: a pending flag plus the payload captured
// with the request pulse. A new request wins over a clear in the same cycle
// so a requester may re-issue in the cycle its completion is signalled.
module mem_port_req_slot #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         set,
  input  logic         clr,
  input  logic [W-1:0] din,
  output logic         pending,
  output logic [W-1:0] dout
);

  // Capture on set, drop pending on clear, reset empties the slot
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= 1'b0;
      dout    <= '0;
    end else if (set) begin
      pending <= 1'b1;
      dout    <= din;
    end else if (clr) begin
      pending <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one AXI_master_SRAM user port between instruction fetch (read only)
// and the LSU (read/write). Request pulses are held in per-requester slots,
// issued to the bus one transaction at a time, and the completion pulse is
// routed back to the owner of the in-flight transaction.
// Build option: define MEM_PORT_ARB_RR_EN for round-robin between IFU and
// LSU; otherwise fixed priority LSU write > LSU read > IFU read.
module mem_port_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ifu_rreq,
  input  logic [ADDR_W-1:0]   ifu_raddr,
  output logic                ifu_rask,
  input  logic                lsu_rreq,
  input  logic [ADDR_W-1:0]   lsu_raddr,
  output logic                lsu_rask,
  input  logic                lsu_wreq,
  input  logic [ADDR_W-1:0]   lsu_waddr,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_wask,
  output logic [DATA_W-1:0]   rdata,
  output logic                bus_rreq,
  output logic [ADDR_W-1:0]   bus_raddr,
  input  logic [DATA_W-1:0]   bus_rdata,
  input  logic                bus_rask,
  output logic                bus_wreq,
  output logic [ADDR_W-1:0]   bus_waddr,
  output logic [DATA_W-1:0]   bus_wdata,
  output logic [DATA_W/8-1:0] bus_wmask,
  input  logic                bus_wask,
  output logic                busy
);
  import mem_port_arb_pkg::*;

  localparam int MASK_W = DATA_W / 8;
  localparam int WR_W   = ADDR_W + DATA_W + MASK_W;

  arb_state_e        state;
  logic              ifu_pend;
  logic              lsu_rd_pend;
  logic              lsu_wr_pend;
  logic [ADDR_W-1:0] ifu_raddr_q;
  logic [ADDR_W-1:0] lsu_raddr_q;
  logic [WR_W-1:0]   wr_q;
  logic              grant_ifu;
  logic              grant_lsu_rd;
  logic              grant_lsu_wr;

  mem_port_req_slot #(.W(ADDR_W)) u_ifu_slot (
    .clk     (clk),
    .rst     (rst),
    .set     (ifu_rreq),
    .clr     (ifu_rask),
    .din     (ifu_raddr),
    .pending (ifu_pend),
    .dout    (ifu_raddr_q)
  );

  mem_port_req_slot #(.W(ADDR_W)) u_lsu_rd_slot (
    .clk     (clk),
    .rst     (rst),
    .set     (lsu_rreq),
    .clr     (lsu_rask),
    .din     (lsu_raddr),
    .pending (lsu_rd_pend),
    .dout    (lsu_raddr_q)
  );

  mem_port_req_slot #(.W(WR_W)) u_lsu_wr_slot (
    .clk     (clk),
    .rst     (rst),
    .set     (lsu_wreq),
    .clr     (lsu_wask),
    .din     ({lsu_waddr, lsu_wdata, lsu_wmask}),
    .pending (lsu_wr_pend),
    .dout    (wr_q)
  );

`ifdef MEM_PORT_ARB_RR_EN
  arb_req_e prio;

  // Hand priority to the requester that did not win the latest grant
  always_ff @(posedge clk) begin
    if (rst) begin
      prio <= REQ_LSU;
    end else if (grant_ifu) begin
      prio <= REQ_LSU;
    end else if (grant_lsu_rd || grant_lsu_wr) begin
      prio <= REQ_IFU;
    end
  end
`endif

  // Pick one pending slot while idle; slots become visible the cycle after capture
  always_comb begin
    grant_ifu    = 1'b0;
    grant_lsu_rd = 1'b0;
    grant_lsu_wr = 1'b0;
    if (!rst && state == IDLE) begin
`ifdef MEM_PORT_ARB_RR_EN
      if (prio == REQ_LSU) begin
        if (lsu_wr_pend)      grant_lsu_wr = 1'b1;
        else if (lsu_rd_pend) grant_lsu_rd = 1'b1;
        else if (ifu_pend)    grant_ifu    = 1'b1;
      end else begin
        if (ifu_pend)         grant_ifu    = 1'b1;
        else if (lsu_wr_pend) grant_lsu_wr = 1'b1;
        else if (lsu_rd_pend) grant_lsu_rd = 1'b1;
      end
`else
      if (lsu_wr_pend)      grant_lsu_wr = 1'b1;
      else if (lsu_rd_pend) grant_lsu_rd = 1'b1;
      else if (ifu_pend)    grant_ifu    = 1'b1;
`endif
    end
  end

  // Track the owner of the in-flight transaction until its matching completion
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (grant_lsu_wr)      state <= WR_LSU;
          else if (grant_lsu_rd) state <= RD_LSU;
          else if (grant_ifu)    state <= RD_IFU;
        end
        RD_IFU:  if (bus_rask) state <= IDLE;
        RD_LSU:  if (bus_rask) state <= IDLE;
        WR_LSU:  if (bus_wask) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus_rreq  = grant_ifu | grant_lsu_rd;
  assign bus_raddr = grant_lsu_rd ? lsu_raddr_q : (grant_ifu ? ifu_raddr_q : '0);
  assign bus_wreq  = grant_lsu_wr;
  assign {bus_waddr, bus_wdata, bus_wmask} = grant_lsu_wr ? wr_q : '0;

  assign ifu_rask = !rst && state == RD_IFU && bus_rask;
  assign lsu_rask = !rst && state == RD_LSU && bus_rask;
  assign lsu_wask = !rst && state == WR_LSU && bus_wask;
  assign rdata    = (ifu_rask || lsu_rask) ? bus_rdata : '0;
  assign busy     = !rst && (state != IDLE || ifu_pend || lsu_rd_pend || lsu_wr_pend);

  // Requesters may not overrun their own slot; a re-request in the ask cycle is fine
  a_lsu_one_kind: assert property (@(posedge clk) disable iff (rst)
    !(lsu_rreq && lsu_wreq));
  a_ifu_no_overrun: assert property (@(posedge clk) disable iff (rst)
    !(ifu_rreq && ifu_pend && !ifu_rask));
  a_lsu_rd_no_overrun: assert property (@(posedge clk) disable iff (rst)
    !(lsu_rreq && lsu_rd_pend && !lsu_rask));
  a_lsu_wr_no_overrun: assert property (@(posedge clk) disable iff (rst)
    !(lsu_wreq && lsu_wr_pend && !lsu_wask));

  // Completions with no matching transaction are dropped; record that they happened
  c_stray_ask: cover property (@(posedge clk) disable iff (rst)
    (bus_rask && state != RD_IFU && state != RD_LSU) || (bus_wask && state != WR_LSU));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed per-cycle vector tables,
// a grant-order sequence, and randomized traffic against a transaction model.
// Honours MEM_PORT_ARB_RR_EN the same way the design does.
module tb_mem_port_arbiter;

  localparam int AW = 64;
  localparam int DW = 64;
  localparam int MW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          ifu_rreq, lsu_rreq, lsu_wreq, bus_rask, bus_wask;
  logic [AW-1:0] ifu_raddr, lsu_raddr, lsu_waddr;
  logic [DW-1:0] lsu_wdata, bus_rdata;
  logic [MW-1:0] lsu_wmask;
  logic          ifu_rask, lsu_rask, lsu_wask, bus_rreq, bus_wreq, busy;
  logic [AW-1:0] bus_raddr, bus_waddr;
  logic [DW-1:0] rdata, bus_wdata;
  logic [MW-1:0] bus_wmask;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .ifu_rreq  (ifu_rreq),
    .ifu_raddr (ifu_raddr),
    .ifu_rask  (ifu_rask),
    .lsu_rreq  (lsu_rreq),
    .lsu_raddr (lsu_raddr),
    .lsu_rask  (lsu_rask),
    .lsu_wreq  (lsu_wreq),
    .lsu_waddr (lsu_waddr),
    .lsu_wdata (lsu_wdata),
    .lsu_wmask (lsu_wmask),
    .lsu_wask  (lsu_wask),
    .rdata     (rdata),
    .bus_rreq  (bus_rreq),
    .bus_raddr (bus_raddr),
    .bus_rdata (bus_rdata),
    .bus_rask  (bus_rask),
    .bus_wreq  (bus_wreq),
    .bus_waddr (bus_waddr),
    .bus_wdata (bus_wdata),
    .bus_wmask (bus_wmask),
    .bus_wask  (bus_wask),
    .busy      (busy)
  );

  typedef struct {
    int            tag;
    logic          rst, ifu_rreq, lsu_rreq, lsu_wreq, bus_rask, bus_wask;
    logic [AW-1:0] ifu_raddr, lsu_raddr, lsu_waddr;
    logic [DW-1:0] lsu_wdata, bus_rdata;
    logic [MW-1:0] lsu_wmask;
    logic          x_rreq, x_wreq, x_ifu_rask, x_lsu_rask, x_lsu_wask, x_busy;
    logic [AW-1:0] x_addr;
    logic [DW-1:0] x_wdata, x_rdata;
    logic [MW-1:0] x_wmask;
  } vec_t;

  vec_t  tbl[$];
  string tnames[4] = '{"single_fetch", "simultaneous", "capture_busy", "reset_mid_read"};

  function automatic vec_t quiet(input int tag, input logic exp_busy);
    vec_t v;
    v.tag = tag;
    v.rst = 1'b0; v.ifu_rreq = 1'b0; v.lsu_rreq = 1'b0; v.lsu_wreq = 1'b0;
    v.bus_rask = 1'b0; v.bus_wask = 1'b0;
    v.ifu_raddr = '0; v.lsu_raddr = '0; v.lsu_waddr = '0;
    v.lsu_wdata = '0; v.bus_rdata = '0; v.lsu_wmask = '0;
    v.x_rreq = 1'b0; v.x_wreq = 1'b0; v.x_ifu_rask = 1'b0; v.x_lsu_rask = 1'b0;
    v.x_lsu_wask = 1'b0; v.x_busy = exp_busy;
    v.x_addr = '0; v.x_wdata = '0; v.x_rdata = '0; v.x_wmask = '0;
    return v;
  endfunction

  function automatic vec_t rstv(input int tag);
    vec_t v;
    v = quiet(tag, 1'b0);
    v.rst = 1'b1;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    rst       = v.rst;
    ifu_rreq  = v.ifu_rreq;  ifu_raddr = v.ifu_raddr;
    lsu_rreq  = v.lsu_rreq;  lsu_raddr = v.lsu_raddr;
    lsu_wreq  = v.lsu_wreq;  lsu_waddr = v.lsu_waddr;
    lsu_wdata = v.lsu_wdata; lsu_wmask = v.lsu_wmask;
    bus_rask  = v.bus_rask;  bus_wask  = v.bus_wask;
    bus_rdata = v.bus_rdata;
  endtask

  task automatic clearInputs();
    applyStimulus(quiet(0, 1'b0));
  endtask

  task automatic checkOutput(input string name, input logic e_rreq, input logic [AW-1:0] e_raddr,
                             input logic e_wreq, input logic [AW-1:0] e_waddr,
                             input logic [DW-1:0] e_wdata, input logic [MW-1:0] e_wmask,
                             input logic e_ifu, input logic e_lsur, input logic e_lsuw,
                             input logic [DW-1:0] e_rdata, input logic e_busy);
    bit ok;
    ok = (bus_rreq === e_rreq) && (bus_wreq === e_wreq) && (ifu_rask === e_ifu) &&
         (lsu_rask === e_lsur) && (lsu_wask === e_lsuw) && (rdata === e_rdata) &&
         (busy === e_busy);
    if (e_rreq && bus_raddr !== e_raddr) ok = 0;
    if (e_wreq && (bus_waddr !== e_waddr || bus_wdata !== e_wdata || bus_wmask !== e_wmask)) ok = 0;
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("[TB] FAIL %s @%0t: got rreq=%0b raddr=%h wreq=%0b waddr=%h wdata=%h wmask=%h ask(i,lr,lw)=%0b%0b%0b rdata=%h busy=%0b; want rreq=%0b raddr=%h wreq=%0b waddr=%h wdata=%h wmask=%h ask=%0b%0b%0b rdata=%h busy=%0b",
               name, $time, bus_rreq, bus_raddr, bus_wreq, bus_waddr, bus_wdata, bus_wmask,
               ifu_rask, lsu_rask, lsu_wask, rdata, busy, e_rreq, e_raddr, e_wreq, e_waddr,
               e_wdata, e_wmask, e_ifu, e_lsur, e_lsuw, e_rdata, e_busy);
    end
  endtask

  task automatic checkVal(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("[TB] FAIL %s @%0t: got %0d, want %0d", name, $time, got, exp);
    end
  endtask

  task automatic doReset();
    @(posedge clk); #1;
    clearInputs();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic buildTables();
    vec_t v;
    // single fetch
    tbl.push_back(rstv(0));
    tbl.push_back(quiet(0, 0));
    v = quiet(0, 0); v.ifu_rreq = 1; v.ifu_raddr = 64'h8000_0000; tbl.push_back(v);
    v = quiet(0, 1); v.x_rreq = 1; v.x_addr = 64'h8000_0000; tbl.push_back(v);
    tbl.push_back(quiet(0, 1));
    tbl.push_back(quiet(0, 1));
    v = quiet(0, 1); v.bus_rask = 1; v.bus_rdata = 64'h13; v.x_ifu_rask = 1; v.x_rdata = 64'h13;
    tbl.push_back(v);
    tbl.push_back(quiet(0, 0));
    // simultaneous IFU read and LSU write
    tbl.push_back(rstv(1));
    tbl.push_back(quiet(1, 0));
    v = quiet(1, 0); v.ifu_rreq = 1; v.ifu_raddr = 64'h8000_0004; v.lsu_wreq = 1;
    v.lsu_waddr = 64'h8000_1000; v.lsu_wdata = 64'hDEAD_BEEF; v.lsu_wmask = 8'h0F; tbl.push_back(v);
    v = quiet(1, 1); v.x_wreq = 1; v.x_addr = 64'h8000_1000; v.x_wdata = 64'hDEAD_BEEF;
    v.x_wmask = 8'h0F; tbl.push_back(v);
    tbl.push_back(quiet(1, 1));
    v = quiet(1, 1); v.bus_wask = 1; v.x_lsu_wask = 1; tbl.push_back(v);
    v = quiet(1, 1); v.x_rreq = 1; v.x_addr = 64'h8000_0004; tbl.push_back(v);
    v = quiet(1, 1); v.bus_rask = 1; v.bus_rdata = 64'h1111; v.x_ifu_rask = 1; v.x_rdata = 64'h1111;
    tbl.push_back(v);
    tbl.push_back(quiet(1, 0));
    // LSU read captured while a fetch is in flight; wrong-kind ask ignored
    tbl.push_back(rstv(2));
    tbl.push_back(quiet(2, 0));
    v = quiet(2, 0); v.ifu_rreq = 1; v.ifu_raddr = 64'h8000_0000; tbl.push_back(v);
    v = quiet(2, 1); v.x_rreq = 1; v.x_addr = 64'h8000_0000; tbl.push_back(v);
    v = quiet(2, 1); v.lsu_rreq = 1; v.lsu_raddr = 64'h8000_2000; tbl.push_back(v);
    v = quiet(2, 1); v.bus_wask = 1; tbl.push_back(v);
    tbl.push_back(quiet(2, 1));
    v = quiet(2, 1); v.bus_rask = 1; v.bus_rdata = 64'hA5A5; v.x_ifu_rask = 1; v.x_rdata = 64'hA5A5;
    tbl.push_back(v);
    v = quiet(2, 1); v.x_rreq = 1; v.x_addr = 64'h8000_2000; tbl.push_back(v);
    v = quiet(2, 1); v.bus_rask = 1; v.bus_rdata = 64'h5A5A; v.x_lsu_rask = 1; v.x_rdata = 64'h5A5A;
    tbl.push_back(v);
    tbl.push_back(quiet(2, 0));
    // reset while a read is outstanding; the late asks are stray
    tbl.push_back(rstv(3));
    tbl.push_back(quiet(3, 0));
    v = quiet(3, 0); v.ifu_rreq = 1; v.ifu_raddr = 64'h8000_0008; tbl.push_back(v);
    v = quiet(3, 1); v.x_rreq = 1; v.x_addr = 64'h8000_0008; tbl.push_back(v);
    tbl.push_back(rstv(3));
    tbl.push_back(quiet(3, 0));
    tbl.push_back(quiet(3, 0));
    v = quiet(3, 0); v.bus_rask = 1; v.bus_rdata = 64'h77; tbl.push_back(v);
    v = quiet(3, 0); v.bus_wask = 1; tbl.push_back(v);
    tbl.push_back(quiet(3, 0));
  endtask

  task automatic runTables();
    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk); #1;
      applyStimulus(tbl[i]);
      @(negedge clk);
      if (!tbl[i].rst)
        checkOutput($sformatf("%s[%0d]", tnames[tbl[i].tag], i), tbl[i].x_rreq, tbl[i].x_addr,
                    tbl[i].x_wreq, tbl[i].x_addr, tbl[i].x_wdata, tbl[i].x_wmask,
                    tbl[i].x_ifu_rask, tbl[i].x_lsu_rask, tbl[i].x_lsu_wask,
                    tbl[i].x_rdata, tbl[i].x_busy);
    end
  endtask

  // Both requesters re-request in their ask cycle for the first four grants.
  task automatic runGrantOrder();
    int exp_owner[5];
    int n, owner, cyc;
    bit ask_due;
`ifdef MEM_PORT_ARB_RR_EN
    exp_owner = '{1, 0, 1, 0, 1};
`else
    exp_owner = '{1, 1, 1, 1, 0};
`endif
    doReset();
    n = 0; owner = 0; cyc = 0; ask_due = 0;
    while ((n < 5 || ask_due) && cyc < 60) begin
      @(posedge clk); #1;
      clearInputs();
      if (cyc == 0) begin
        ifu_rreq = 1; ifu_raddr = 64'h1000_0000;
        lsu_rreq = 1; lsu_raddr = 64'h2000_0000;
      end
      if (ask_due) begin
        bus_rask = 1; bus_rdata = 64'h100 + 64'(n);
        if (n < 4) begin
          if (owner == 1) begin lsu_rreq = 1; lsu_raddr = 64'h2000_0000 + 64'(n); end
          else begin ifu_rreq = 1; ifu_raddr = 64'h1000_0000 + 64'(n); end
        end
      end
      @(negedge clk);
      if (ask_due) begin
        checkVal($sformatf("grant%0d_ask", n), int'({ifu_rask, lsu_rask}), (owner == 1) ? 1 : 2);
        ask_due = 0;
      end
      if (bus_rreq) begin
        owner = (bus_raddr[31:28] == 4'h2) ? 1 : 0;
        n++;
        if (n <= 5) checkVal($sformatf("grant%0d_owner", n), owner, exp_owner[n-1]);
        else checkVal("extra_grant", n, 5);
        ask_due = 1;
      end
      cyc++;
    end
    if (cyc >= 60) begin
      vectors++; miscompares++;
      $display("[TB] FAIL grant_timeout: got %0d grants, want 5", n);
    end
    @(posedge clk); #1;
    clearInputs();
    @(negedge clk);
    checkVal("grant_drain_busy", int'(busy), 0);
  endtask

  // Randomized traffic against a transaction-level model of the slots and owner.
  task automatic runRandom(input int ncycles);
    bit            m_pend[3];
    logic [AW-1:0] m_addr[3];
    logic [DW-1:0] m_wdata;
    logic [MW-1:0] m_wmask;
    int            m_owner, m_ask_at, g, done, r;
    bit            lsu_first, m_prio_lsu;
    logic [DW-1:0] e_rdata;
    doReset();
    for (int k = 0; k < 3; k++) begin m_pend[k] = 0; m_addr[k] = '0; end
    m_wdata = '0; m_wmask = '0; m_owner = -1; m_ask_at = 0; m_prio_lsu = 1;
    for (int cyc = 0; cyc < ncycles; cyc++) begin
      @(posedge clk); #1;
      clearInputs();
      g = -1;
      if (m_owner < 0) begin
`ifdef MEM_PORT_ARB_RR_EN
        lsu_first = m_prio_lsu;
`else
        lsu_first = 1;
`endif
        if (lsu_first) g = m_pend[2] ? 2 : m_pend[1] ? 1 : m_pend[0] ? 0 : -1;
        else           g = m_pend[0] ? 0 : m_pend[2] ? 2 : m_pend[1] ? 1 : -1;
      end
      bus_rdata = {$urandom, $urandom};
      done = -1;
      if (m_owner >= 0 && cyc == m_ask_at) begin
        if (m_owner == 2) bus_wask = 1; else bus_rask = 1;
        done = m_owner;
      end else if ($urandom_range(0, 15) == 0) begin
        if (m_owner < 0) begin
          if ($urandom_range(0, 1) == 0) bus_rask = 1; else bus_wask = 1;
        end else if (m_owner == 2) bus_rask = 1;
        else bus_wask = 1;
      end
      if ((!m_pend[0] || done == 0) && $urandom_range(0, 2) == 0) begin
        ifu_rreq = 1; ifu_raddr = {$urandom, $urandom};
      end
      r = int'($urandom_range(0, 5));
      if (r == 0 && (!m_pend[1] || done == 1)) begin
        lsu_rreq = 1; lsu_raddr = {$urandom, $urandom};
      end else if (r == 1 && (!m_pend[2] || done == 2)) begin
        lsu_wreq = 1; lsu_waddr = {$urandom, $urandom};
        lsu_wdata = {$urandom, $urandom}; lsu_wmask = 8'($urandom);
      end
      e_rdata = (done == 0 || done == 1) ? bus_rdata : '0;
      @(negedge clk);
      checkOutput($sformatf("random[%0d]", cyc), g == 0 || g == 1,
                  (g == 0 || g == 1) ? m_addr[(g < 0) ? 0 : g] : '0,
                  g == 2, m_addr[2], m_wdata, m_wmask, done == 0, done == 1, done == 2,
                  e_rdata, m_owner >= 0 || m_pend[0] || m_pend[1] || m_pend[2]);
      if (done >= 0) begin m_pend[done] = 0; m_owner = -1; end
      if (g >= 0) begin
        m_owner = g;
        m_ask_at = cyc + int'($urandom_range(1, 4));
        m_prio_lsu = (g == 0);
      end
      if (ifu_rreq) begin m_pend[0] = 1; m_addr[0] = ifu_raddr; end
      if (lsu_rreq) begin m_pend[1] = 1; m_addr[1] = lsu_raddr; end
      if (lsu_wreq) begin
        m_pend[2] = 1; m_addr[2] = lsu_waddr; m_wdata = lsu_wdata; m_wmask = lsu_wmask;
      end
    end
  endtask

  initial begin
    clearInputs();
    rst = 1'b1;
    buildTables();
    runTables();
    runGrantOrder();
    runRandom(3000);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
